// File: rtl/pixseq_pkg.sv
// Shared types and constants for the pixel-array frame sequencer.
`timescale 1ns/1ps
package pixseq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERASE_S,
        EXPOSE_S,
        CONVERT_S,
        READ1_S,
        READ2_S,
        DONE
    } state_t;

    localparam int TIMER_W            = 16;
    localparam int DEF_ERASE_CYCLES   = 5;
    localparam int DEF_CONVERT_CYCLES = 255;
    localparam int DEF_READ_CYCLES    = 2;

endpackage

// File: rtl/phase_timer.sv
// Down-counter shared by all timed phases; a load of N makes last rise on the Nth cycle.
`timescale 1ns/1ps
module phase_timer
    import pixseq_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               last
);

    logic [TIMER_W-1:0] count_reg;

    // The load cycle itself is the first counted cycle, hence the minus one.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value - TIMER_W'(1);
        end else if (count_reg != '0) begin
            count_reg <= count_reg - TIMER_W'(1);
        end
    end

    assign last = (count_reg == '0);

endmodule

// File: rtl/pixel_sequencer.sv
// Frame controller for the pixel array phase strobes (erase/expose/convert/read1/read2).
// Optional frame counter output FRAME_CNT when PIXSEQ_FRAME_CNT_EN is defined.
`timescale 1ns/1ps
module pixel_sequencer
    import pixseq_pkg::*;
#(
    parameter int ERASE_CYCLES   = DEF_ERASE_CYCLES,
    parameter int CONVERT_CYCLES = DEF_CONVERT_CYCLES,
    parameter int READ_CYCLES    = DEF_READ_CYCLES
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        CONTINUOUS,
    input  logic        ABORT,
    input  logic [15:0] EXPOSE_LEN,
    output logic        ERASE,
    output logic        EXPOSE,
    output logic        CONVERT,
    output logic        READ1,
    output logic        READ2,
    output logic        BUSY,
    output logic        ROW_VALID,
    output logic        ROW_SEL,
    output logic        FRAME_DONE
`ifdef PIXSEQ_FRAME_CNT_EN
    ,
    output logic [15:0] FRAME_CNT
`endif
);

    localparam logic [TIMER_W-1:0] ERASE_LOAD   = TIMER_W'(ERASE_CYCLES);
    localparam logic [TIMER_W-1:0] CONVERT_LOAD = TIMER_W'(CONVERT_CYCLES);
    localparam logic [TIMER_W-1:0] READ_LOAD    = TIMER_W'(READ_CYCLES);

    state_t             state_reg, state_next;
    logic [15:0]        exp_len_reg;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_last;
    logic               latch_len;
    logic               enter_read2;
    logic               enter_done;

    logic erase_reg, expose_reg, convert_reg, read1_reg, read2_reg;
    logic busy_reg, row_valid_reg, row_sel_reg, frame_done_reg;

    phase_timer u_timer (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (timer_load),
        .load_value (timer_value),
        .last       (timer_last)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Each transition into a timed state also loads that state's length.
    always_comb begin
        state_next  = state_reg;
        timer_load  = 1'b0;
        timer_value = '0;
        latch_len   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (START) begin
                    state_next  = ERASE_S;
                    timer_load  = 1'b1;
                    timer_value = ERASE_LOAD;
                    latch_len   = 1'b1;
                end
            end
            ERASE_S: begin
                if (timer_last) begin
                    state_next  = EXPOSE_S;
                    timer_load  = 1'b1;
                    timer_value = exp_len_reg;
                end
            end
            EXPOSE_S: begin
                if (timer_last) begin
                    state_next  = CONVERT_S;
                    timer_load  = 1'b1;
                    timer_value = CONVERT_LOAD;
                end
            end
            CONVERT_S: begin
                if (timer_last) begin
                    state_next  = READ1_S;
                    timer_load  = 1'b1;
                    timer_value = READ_LOAD;
                end
            end
            READ1_S: begin
                if (timer_last) begin
                    state_next  = READ2_S;
                    timer_load  = 1'b1;
                    timer_value = READ_LOAD;
                end
            end
            READ2_S: begin
                if (timer_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (CONTINUOUS) begin
                    state_next  = ERASE_S;
                    timer_load  = 1'b1;
                    timer_value = ERASE_LOAD;
                    latch_len   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (ABORT) begin
            state_next = IDLE;
            timer_load = 1'b0;
            latch_len  = 1'b0;
        end
    end

    // A zero exposure request is stored as one so the timer never sees a zero load.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            exp_len_reg <= 16'd1;
        end else if (latch_len) begin
            exp_len_reg <= (EXPOSE_LEN == 16'd0) ? 16'd1 : EXPOSE_LEN;
        end
    end

    assign enter_read2 = (state_reg == READ1_S) && (state_next == READ2_S);
    assign enter_done  = (state_reg != DONE) && (state_next == DONE);

    // Outputs decode the next state so they line up exactly with the state they mark.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            erase_reg      <= 1'b0;
            expose_reg     <= 1'b0;
            convert_reg    <= 1'b0;
            read1_reg      <= 1'b0;
            read2_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            row_valid_reg  <= 1'b0;
            row_sel_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            erase_reg      <= (state_next == ERASE_S);
            expose_reg     <= (state_next == EXPOSE_S);
            convert_reg    <= (state_next == CONVERT_S);
            read1_reg      <= (state_next == READ1_S);
            read2_reg      <= (state_next == READ2_S);
            busy_reg       <= (state_next != IDLE);
            row_valid_reg  <= enter_read2 || enter_done;
            frame_done_reg <= enter_done;
            if (enter_read2) begin
                row_sel_reg <= 1'b0;
            end else if (enter_done) begin
                row_sel_reg <= 1'b1;
            end
        end
    end

    assign ERASE      = erase_reg;
    assign EXPOSE     = expose_reg;
    assign CONVERT    = convert_reg;
    assign READ1      = read1_reg;
    assign READ2      = read2_reg;
    assign BUSY       = busy_reg;
    assign ROW_VALID  = row_valid_reg;
    assign ROW_SEL    = row_sel_reg;
    assign FRAME_DONE = frame_done_reg;

`ifdef PIXSEQ_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frame_cnt_reg <= 16'd0;
        end else if (enter_done) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign FRAME_CNT = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_pixel_sequencer.sv
// Self-checking bench for pixel_sequencer: per-cycle comparison against a frame-schedule model.
`timescale 1ns/1ps
module tb_pixel_sequencer;

    localparam int ER = 5;
    localparam int CV = 255;
    localparam int RD = 2;

    logic        CLK = 1'b0;
    logic        RESET, START, CONTINUOUS, ABORT;
    logic [15:0] EXPOSE_LEN;
    logic        ERASE, EXPOSE, CONVERT, READ1, READ2;
    logic        BUSY, ROW_VALID, ROW_SEL, FRAME_DONE;
`ifdef PIXSEQ_FRAME_CNT_EN
    logic [15:0] FRAME_CNT;
`endif

    pixel_sequencer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .CONTINUOUS (CONTINUOUS),
        .ABORT      (ABORT),
        .EXPOSE_LEN (EXPOSE_LEN),
        .ERASE      (ERASE),
        .EXPOSE     (EXPOSE),
        .CONVERT    (CONVERT),
        .READ1      (READ1),
        .READ2      (READ2),
        .BUSY       (BUSY),
        .ROW_VALID  (ROW_VALID),
        .ROW_SEL    (ROW_SEL),
        .FRAME_DONE (FRAME_DONE)
`ifdef PIXSEQ_FRAME_CNT_EN
        ,
        .FRAME_CNT  (FRAME_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   frame_no = 0;
    int   frames_m = 0;
    logic row_sel_m = 1'b0;

    // {ERASE,EXPOSE,CONVERT,READ1,READ2,BUSY,ROW_VALID,ROW_SEL,FRAME_DONE}
    function automatic logic [8:0] obs_vec();
        return {ERASE, EXPOSE, CONVERT, READ1, READ2, BUSY, ROW_VALID, ROW_SEL, FRAME_DONE};
    endfunction

    function automatic logic [8:0] idle_vec();
        return {5'b00000, 1'b0, 1'b0, row_sel_m, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Builds the whole expected frame from phase lengths, then walks it cycle by cycle
    // while throwing random START/EXPOSE_LEN noise at the DUT.
    task automatic check_frame(input int e_eff, output int next_eff);
        logic [8:0]  q[$];
        logic [15:0] next_raw;
        int          last_i;
        next_raw = 16'd0;
        for (int i = 0; i < ER; i++)    q.push_back({5'b10000, 1'b1, 1'b0, row_sel_m, 1'b0});
        for (int i = 0; i < e_eff; i++) q.push_back({5'b01000, 1'b1, 1'b0, row_sel_m, 1'b0});
        for (int i = 0; i < CV; i++)    q.push_back({5'b00100, 1'b1, 1'b0, row_sel_m, 1'b0});
        for (int i = 0; i < RD; i++)    q.push_back({5'b00010, 1'b1, 1'b0, row_sel_m, 1'b0});
        q.push_back({5'b00001, 1'b1, 1'b1, 1'b0, 1'b0});
        for (int i = 1; i < RD; i++)    q.push_back({5'b00001, 1'b1, 1'b0, 1'b0, 1'b0});
        q.push_back({5'b00000, 1'b1, 1'b1, 1'b1, 1'b1});
        row_sel_m = 1'b1;
        last_i = q.size() - 1;
        for (int i = 0; i <= last_i; i++) begin
            check($sformatf("frame%0d_cyc%0d", frame_no, i), 16'(obs_vec()), 16'(q[i]));
            if (i == last_i) begin
                START      = 1'b0;
                EXPOSE_LEN = 16'($urandom_range(0, 40));
                next_raw   = EXPOSE_LEN;
            end else begin
                START      = 1'($urandom_range(0, 1));
                EXPOSE_LEN = 16'($urandom_range(0, 60));
            end
            @(negedge CLK);
        end
        START = 1'b0;
        frames_m++;
        $display("frame %0d: expose %0d, %0d cycles compared", frame_no, e_eff, q.size());
        frame_no++;
        next_eff = (next_raw == 16'd0) ? 1 : int'(next_raw);
    endtask

    task automatic start_frame(input logic [15:0] len);
        EXPOSE_LEN = len;
        START      = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic check_count();
`ifdef PIXSEQ_FRAME_CNT_EN
        check("frame_cnt", FRAME_CNT, 16'(frames_m));
`endif
    endtask

    initial begin
        int          nxt;
        int          e;
        logic [15:0] len;

        RESET = 1'b1; START = 1'b0; CONTINUOUS = 1'b0; ABORT = 1'b0; EXPOSE_LEN = 16'd0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", 16'(obs_vec()), 16'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check("idle_after_reset", 16'(obs_vec()), 16'(idle_vec()));
        check_count();

        // Single frame, exposure 10, then BUSY must fall right after DONE.
        start_frame(16'd10);
        check_frame(10, nxt);
        check("idle_after_frame", 16'(obs_vec()), 16'(idle_vec()));
        repeat (3) @(negedge CLK);
        check("idle_hold", 16'(obs_vec()), 16'(idle_vec()));
        check_count();

        // Zero exposure is one cycle.
        start_frame(16'd0);
        check_frame(1, nxt);
        check("idle_after_zero_exp", 16'(obs_vec()), 16'(idle_vec()));

        // Three back-to-back frames in continuous mode.
        CONTINUOUS = 1'b1;
        len = 16'($urandom_range(0, 40));
        start_frame(len);
        e = (len == 16'd0) ? 1 : int'(len);
        check_frame(e, nxt);
        check_frame(nxt, nxt);
        CONTINUOUS = 1'b0;
        check_frame(nxt, nxt);
        check("idle_after_continuous", 16'(obs_vec()), 16'(idle_vec()));
        check_count();

        // Abort in the 100th CONVERT cycle, START asserted alongside must lose.
        len = 16'($urandom_range(1, 30));
        start_frame(len);
        repeat (ER + int'(len) + 99) @(negedge CLK);
        check("convert_100th", 16'(CONVERT), 16'd1);
        ABORT = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        START = 1'b0;
        for (int i = 0; i < 300; i++) begin
            check($sformatf("abort_idle%0d", i), 16'(obs_vec()), 16'(idle_vec()));
            @(negedge CLK);
        end
        check_count();

        // Asynchronous reset in the middle of EXPOSE.
        start_frame(16'd20);
        repeat (ER + 5) @(negedge CLK);
        check("expose_before_reset", 16'(EXPOSE), 16'd1);
        #1 RESET = 1'b1;
        #1 check("async_reset_drop", 16'(obs_vec()), 16'd0);
        row_sel_m = 1'b0;
        frames_m  = 0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("idle_after_async_reset", 16'(obs_vec()), 16'(idle_vec()));
        check_count();
        len = 16'($urandom_range(0, 40));
        start_frame(len);
        e = (len == 16'd0) ? 1 : int'(len);
        check_frame(e, nxt);
        check("idle_final", 16'(obs_vec()), 16'(idle_vec()));
        check_count();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
